// File: rtl/tcore_param.sv
`default_nettype none
// ============================================================================
//  Module      : tcore_param (package)
//  Description : Shared core parameters for the writeback slice: datapath
//                width, writeback source encoding, default ALU starvation
//                limit and a small destination-register helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tcore_param;

  localparam int XLEN            = 32;
  localparam int WB_STARVE_LIMIT = 4;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // x0 is hardwired to zero, so a beat targeting it never writes.
  function automatic logic rd_writes(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Two-way writeback arbiter. Loads normally win; after
//                STARVE_LIMIT consecutive losses the ALU is forced to win
//                one grant.
//  Ports       : clk_i, rst_ni      - clock, asynchronous active-low reset
//                alu_valid_i        - ALU result pending
//                lsu_valid_i        - load result pending
//                alu_grant_o        - ALU channel ready (combinational)
//                lsu_grant_o        - LSU channel ready (combinational)
//                src_o              - selected source for the data mux
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import tcore_param::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    alu_valid_i,
  input  logic    lsu_valid_i,
  output logic    alu_grant_o,
  output logic    lsu_grant_o,
  output wb_src_e src_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             force_alu;

  always_comb begin
    force_alu   = alu_valid_i && (starve_cnt == CNT_MAX);
    lsu_grant_o = lsu_valid_i && !force_alu;
    alu_grant_o = alu_valid_i && !lsu_grant_o;
    src_o       = lsu_grant_o ? WB_LSU : WB_ALU;

    // Only a genuine ALU loss (both pending, LSU wins) counts toward
    // starvation; anything else resets the streak.
    starve_cnt_nxt = '0;
    if (alu_valid_i && lsu_valid_i && lsu_grant_o) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX
                                               : starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Merges ALU and load results onto a single register-file
//                write port with one cycle of latency, tracks pending
//                destination writes in a 32-entry busy scoreboard and
//                optionally forwards the in-flight write to two read ports.
//  Build macro : TCORE_WB_BYPASS_EN - when defined, the bypass compare logic
//                is built; otherwise the bypass outputs are tied to zero.
//  Ports       : clk_i, rst_ni                 - clock, async active-low reset
//                alu_valid_i/ready_o/rd_i/data_i - ALU result channel
//                lsu_valid_i/ready_o/rd_i/data_i - load result channel
//                alloc_en_i, alloc_rd_i        - issue-side allocation
//                busy_o                        - pending-write scoreboard
//                rf_we_o/waddr_o/wdata_o       - register-file write port
//                r1/r2_addr_i, fwd1/2_hit_o,
//                fwd1/2_data_o                 - bypass port
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
  import tcore_param::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            alloc_en_i,
  input  logic [4:0]      alloc_rd_i,
  output logic [31:0]     busy_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  input  logic [4:0]      r1_addr_i,
  input  logic [4:0]      r2_addr_i,
  output logic            fwd1_hit_o,
  output logic            fwd2_hit_o,
  output logic [XLEN-1:0] fwd1_data_o,
  output logic [XLEN-1:0] fwd2_data_o
);

  wb_src_e         src;
  logic            beat_fire;
  logic [4:0]      beat_rd;
  logic [XLEN-1:0] beat_data;
  logic            wr_en;
  logic [31:0]     busy_nxt;

  wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arbiter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alu_valid_i (alu_valid_i),
    .lsu_valid_i (lsu_valid_i),
    .alu_grant_o (alu_ready_o),
    .lsu_grant_o (lsu_ready_o),
    .src_o       (src)
  );

  always_comb begin
    beat_fire = (alu_valid_i && alu_ready_o) || (lsu_valid_i && lsu_ready_o);
    beat_rd   = (src == WB_LSU) ? lsu_rd_i   : alu_rd_i;
    beat_data = (src == WB_LSU) ? lsu_data_i : alu_data_i;
    // rd=0 beats are consumed but dropped here.
    wr_en     = beat_fire && rd_writes(beat_rd);

    busy_nxt = busy_o;
    if (wr_en) begin
      busy_nxt[beat_rd] = 1'b0;
    end
    // Allocation is applied last so a coincident alloc of the same rd wins.
    if (alloc_en_i && rd_writes(alloc_rd_i)) begin
      busy_nxt[alloc_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      busy_o     <= '0;
    end else begin
      rf_we_o <= wr_en;
      busy_o  <= busy_nxt;
      // Address/data only move on a real write; idle cycles hold them.
      if (wr_en) begin
        rf_waddr_o <= beat_rd;
        rf_wdata_o <= beat_data;
      end
    end
  end

`ifdef TCORE_WB_BYPASS_EN
  always_comb begin
    fwd1_hit_o  = rf_we_o && (rf_waddr_o == r1_addr_i) && rd_writes(r1_addr_i);
    fwd2_hit_o  = rf_we_o && (rf_waddr_o == r2_addr_i) && rd_writes(r2_addr_i);
    fwd1_data_o = fwd1_hit_o ? rf_wdata_o : '0;
    fwd2_data_o = fwd2_hit_o ? rf_wdata_o : '0;
  end
`else
  // Read addresses are kept on the port list so both builds share one
  // interface; they have no load in this build.
  logic unused_bypass_addr;
  assign unused_bypass_addr = ^{r1_addr_i, r2_addr_i};
  assign fwd1_hit_o  = 1'b0;
  assign fwd2_hit_o  = 1'b0;
  assign fwd1_data_o = '0;
  assign fwd2_data_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Self-checking bench for writeback_unit. Directed scenarios
//                followed by random traffic, all compared against a
//                behavioural model of grant, write and scoreboard rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, alloc_rd, r1_addr, r2_addr, rf_waddr;
  logic [31:0] alu_data, lsu_data, busy, rf_wdata, fwd1_data, fwd2_data;
  logic        alloc_en, rf_we, fwd1_hit, fwd2_hit;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        last_alu_ready;

  always #5 clk = ~clk;

  writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .alu_valid_i (alu_valid),
    .alu_ready_o (alu_ready),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .lsu_valid_i (lsu_valid),
    .lsu_ready_o (lsu_ready),
    .lsu_rd_i    (lsu_rd),
    .lsu_data_i  (lsu_data),
    .alloc_en_i  (alloc_en),
    .alloc_rd_i  (alloc_rd),
    .busy_o      (busy),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .r1_addr_i   (r1_addr),
    .r2_addr_i   (r2_addr),
    .fwd1_hit_o  (fwd1_hit),
    .fwd2_hit_o  (fwd2_hit),
    .fwd1_data_o (fwd1_data),
    .fwd2_data_o (fwd2_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {hit, data} expected on a bypass port reading address a.
  function automatic logic [32:0] fwd_exp(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
`ifdef TCORE_WB_BYPASS_EN
    if (m_we && m_addr == a && a != 5'd0) r = {1'b1, m_data};
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    alloc_en  = 0; alloc_rd = '0;
    r1_addr   = '0; r2_addr = '0;
  endtask

  // One clock cycle: apply inputs, check combinational outputs, advance the
  // model, clock, then check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic ae, input logic [4:0] ar,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic        ea, el;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [32:0] f1, f2;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alloc_en  = ae; alloc_rd = ar;
    r1_addr   = r1; r2_addr = r2;
    #1;
    f1 = fwd_exp(r1);
    f2 = fwd_exp(r2);
    check("fwd1_hit",  fwd1_hit,  f1[32]);
    check("fwd1_data", fwd1_data, f1[31:0]);
    check("fwd2_hit",  fwd2_hit,  f2[32]);
    check("fwd2_data", fwd2_data, f2[31:0]);

    el = lv && !(av && m_starve == LIMIT);
    ea = av && !el;
    check("alu_ready", alu_ready, ea);
    check("lsu_ready", lsu_ready, el);
    last_alu_ready = alu_ready;

    wrd = el ? lrd : ard;
    wd  = el ? ld  : ad;
    if (av && lv && el) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else                m_starve = 0;
    m_we = (ea || el) && wrd != 5'd0;
    if (m_we) begin
      m_addr = wrd;
      m_data = wd;
      m_busy[wrd] = 1'b0;
    end
    if (ae && ar != 5'd0) m_busy[ar] = 1'b1;

    @(posedge clk);
    #1;
    check("rf_we",    rf_we,    m_we);
    check("rf_waddr", rf_waddr, m_addr);
    check("rf_wdata", rf_wdata, m_data);
    check("busy",     busy,     m_busy);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_ni = 1'b0;
    // A beat presented during reset must vanish.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1111_2222;
    repeat (2) @(posedge clk);
    #1;
    check("reset_we",    rf_we,    1'b0);
    check("reset_waddr", rf_waddr, 5'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_busy",  busy,     32'd0);
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                 // no ghost write

    // ALU only, rd=5 previously allocated.
    step(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    check("busy5_set", busy[5], 1'b1);
    step(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("alu_we5",    rf_we,    1'b1);
    check("alu_addr5",  rf_waddr, 5'd5);
    check("alu_data5",  rf_wdata, 32'h1234);
    check("busy5_clr",  busy[5],  1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_hold_addr", rf_waddr, 5'd5);

    // Contention: LSU 4 times, ALU on 5th, then LSU again.
    for (int i = 0; i < 6; i++) begin
      step(1, 5'd10, 32'hA000 + i, 1, 5'd11, 32'hB000 + i, 0, 0, 0, 0);
      check("contention_alu_grant", last_alu_ready, (i == 4) ? 1'b1 : 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rd=0 beat is consumed with no write.
    step(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0);
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    check("rd0_ready", last_alu_ready, 1'b1);
    check("rd0_no_we", rf_we, 1'b0);
    check("rd0_busy",  busy[12], 1'b1);

    // Allocate and write rd=7 on the same edge: alloc wins.
    step(1, 5'd7, 32'h7777, 0, 0, 0, 1, 5'd7, 0, 0);
    check("alloc_wins7", busy[7], 1'b1);
    // Allocating x0 never marks it.
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);

    // Bypass on x9.
    step(0, 0, 0, 1, 5'd9, 32'hCAFE, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    end

    // Reset dropped the cycle after an acceptance.
    step(0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    step(1, 5'd3, 32'h3333, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("async_rst_we",   rf_we,    1'b0);
    check("async_rst_busy", busy,     32'd0);
    check("async_rst_addr", rf_waddr, 5'd0);
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h4444;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b1;
    // First edge after release accepts a beat.
    step(1, 5'd6, 32'h6666, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_we",   rf_we,    1'b1);
    check("post_rst_addr", rf_waddr, 5'd6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
